// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the in-order
// pipeline writeback (always wins) and a buffered long-latency result stream.
// Also keeps a per-register busy scoreboard and a starvation bubble request.
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            p_valid,
    input  logic [4:0]      p_rd,
    input  logic [XLEN-1:0] p_data,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [4:0]      s_rd,
    input  logic [XLEN-1:0] s_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic [31:0]     busy,
    output logic            stall_req,
    output logic            err_waw,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LIMIT      = CW'(STARVE_LIMIT);

    logic [4:0]      fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [CW-1:0]   starve_cnt;

    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;
    logic [31:0]     busy_next;
    logic            waw_next;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign s_ready   = !full && !rst;
    assign push      = s_valid && s_ready;
    assign pop       = !p_valid && !empty;
    assign head_rd   = fifo_rd[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    assign stall_req = (starve_cnt >= LIMIT);

    // Write-port mux: pipeline first, then FIFO head, otherwise idle.
    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = '0;
        rf_wdata = '0;
        if (p_valid) begin
            rf_we    = (p_rd != 5'd0);
            rf_rd    = p_rd;
            rf_wdata = p_data;
        end else if (!empty) begin
            rf_we    = (head_rd != 5'd0);
            rf_rd    = head_rd;
            rf_wdata = head_data;
        end
    end

    // Scoreboard next state: clear on pop first so a same-cycle issue wins.
    always_comb begin
        busy_next = busy;
        waw_next  = 1'b0;
        if (pop && head_rd != 5'd0) begin
            busy_next[head_rd] = 1'b0;
        end
        if (iss_valid && iss_rd != 5'd0) begin
            busy_next[iss_rd] = 1'b1;
            waw_next = busy[iss_rd] && !(pop && head_rd == iss_rd);
        end
        busy_next[0] = 1'b0;
    end

    // FIFO storage write; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= s_rd;
            fifo_data[wr_ptr] <= s_data;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Busy scoreboard and write-after-write error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= '0;
            err_waw <= 1'b0;
        end else begin
            busy    <= busy_next;
            err_waw <= waw_next;
        end
    end

    // Saturating starvation counter: counts cycles the head is blocked.
    always_ff @(posedge clk) begin
        if (rst || pop || empty) begin
            starve_cnt <= '0;
        end else if (p_valid && starve_cnt != '1) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a queue-based reference model
// predicts every cycle's outputs; a monitor compares them at the falling edge.
module tb_regfile_wb_arbiter;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            p_valid;
    logic [4:0]      p_rd;
    logic [XLEN-1:0] p_data;
    logic            s_valid;
    logic            s_ready;
    logic [4:0]      s_rd;
    logic [XLEN-1:0] s_data;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [31:0]     busy;
    logic            stall_req;
    logic            err_waw;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;

    regfile_wb_arbiter #(
        .XLEN(XLEN),
        .FIFO_DEPTH(DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_rd(s_rd), .s_data(s_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .busy(busy), .stall_req(stall_req), .err_waw(err_waw),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] busy;
        logic        stall;
        logic        sready;
        logic        waw;
    } exp_t;

    // Reference model state
    ent_t mq[$];
    bit   mbusy[32];
    int   starve;
    bit   mwaw;

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("rf_we",     {31'd0, rf_we},     {31'd0, e.we});
                chk("rf_rd",     {27'd0, rf_rd},     {27'd0, e.rd});
                chk("rf_wdata",  rf_wdata,           e.wdata);
                chk("busy",      busy,               e.busy);
                chk("stall_req", {31'd0, stall_req}, {31'd0, e.stall});
                chk("s_ready",   {31'd0, s_ready},   {31'd0, e.sready});
                chk("err_waw",   {31'd0, err_waw},   {31'd0, e.waw});
            end
        end
    end

    // One clock cycle: drive inputs, predict outputs, then advance the model.
    task automatic cyc(input bit r, input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                       input bit sv, input logic [4:0] srd, input logic [31:0] sd,
                       input bit iv, input logic [4:0] ird);
        exp_t e;
        bit   rdy, do_pop, was_empty;
        ent_t h;
        rst = r; p_valid = pv; p_rd = prd; p_data = pd;
        s_valid = sv; s_rd = srd; s_data = sd; iss_valid = iv; iss_rd = ird;

        rdy = !r && (mq.size() < DEPTH);
        e.sready = rdy;
        e.stall  = (starve >= LIMIT);
        e.waw    = mwaw;
        e.busy   = '0;
        for (int i = 1; i < 32; i++) e.busy[i] = mbusy[i];
        if (pv) begin
            e.we = (prd != 0); e.rd = prd; e.wdata = pd;
        end else if (mq.size() > 0) begin
            e.we = (mq[0].rd != 0); e.rd = mq[0].rd; e.wdata = mq[0].d;
        end else begin
            e.we = 1'b0; e.rd = '0; e.wdata = '0;
        end
        expq.push_back(e);

        @(posedge clk);
        if (r) begin
            mq.delete();
            for (int i = 0; i < 32; i++) mbusy[i] = 0;
            starve = 0;
            mwaw = 0;
        end else begin
            was_empty = (mq.size() == 0);
            do_pop = !pv && !was_empty;
            mwaw = 0;
            if (do_pop) begin
                h = mq.pop_front();
                if (h.rd != 0) mbusy[h.rd] = 0;
            end
            if (iv && ird != 0) begin
                if (mbusy[ird] && !(do_pop && h.rd == ird)) mwaw = 1;
                mbusy[ird] = 1;
            end
            if (sv && rdy) begin
                h.rd = srd; h.d = sd;
                mq.push_back(h);
            end
            if (do_pop || was_empty) starve = 0;
            else if (pv && starve < 1000) starve++;
        end
        #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; p_valid = 0; p_rd = 0; p_data = 0;
        s_valid = 0; s_rd = 0; s_data = 0; iss_valid = 0; iss_rd = 0;
        starve = 0; mwaw = 0;
        for (int i = 0; i < 32; i++) mbusy[i] = 0;
        @(posedge clk); #1;

        // Reset held with s_valid high: nothing may be pushed
        cyc(1, 0, 0, 0, 1, 4, 32'h44, 0, 0);
        cyc(1, 0, 0, 0, 1, 4, 32'h44, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Pipeline priority over buffered {7, 0x11}
        cyc(0, 1, 1, 32'h1, 1, 7, 32'h11, 0, 0);
        cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Scoreboard set, write-after-write, then clear on drain
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 9);
        cyc(0, 1, 2, 32'h2, 1, 9, 32'hA5, 0, 0);
        cyc(0, 1, 2, 32'h3, 0, 0, 0, 1, 9);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Full FIFO with pipeline held high; also drives starvation
        cyc(0, 1, 6, 32'h60, 1, 1, 32'h101, 0, 0);
        cyc(0, 1, 6, 32'h61, 1, 2, 32'h102, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 6, 32'h62 + i, 1, 3, 32'h103, 0, 0);
        cyc(0, 0, 0, 0, 1, 3, 32'h103, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // x0 entry and same-cycle set/clear collision on x3
        cyc(0, 0, 0, 0, 1, 0, 32'hFF, 1, 3);
        cyc(0, 1, 8, 32'h8, 1, 3, 32'h33, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-operation with entries buffered
        cyc(0, 1, 1, 32'h1, 1, 12, 32'hC, 1, 12);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        n = 600;
        for (int i = 0; i < n; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 99) < 55), 5'($urandom_range(0, 31)), $urandom,
                ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 6)), $urandom,
                ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 6)));
        end

        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL monitor_drain: %0d predictions left, expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
